// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned N_DEFAULT = 256;
    localparam int unsigned CNT_W     = $clog2(N_DEFAULT) + 1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step
#(
    parameter int unsigned N = 256
)
(
    input  logic [N:0]   r,
    input  logic [N-1:0] d,
    input  logic [N-1:0] b,
    output logic [N:0]   r_next,
    output logic [N-1:0] d_next,
    output logic         qbit
);

    logic [N:0] w_shift;
    logic [N:0] w_diff;

    always_comb begin
        w_shift = {r[N-1:0], d[N-1]};
        w_diff  = w_shift - {1'b0, b};
        qbit    = (w_shift >= {1'b0, b});
        r_next  = qbit ? w_diff : w_shift;
        d_next  = {d[N-2:0], qbit};
    end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned N = 256
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         busy,
    output logic         data_rdy,
    output logic         div_by_zero,
    output logic [1:0]   state
);

    localparam int unsigned CNT_W_L = (N == N_DEFAULT) ? CNT_W : cnt_width(N);

    state_t             r_state;
    state_t             w_state_next;
    logic [N-1:0]       r_d;
    logic [N:0]         r_r;
    logic [N-1:0]       r_b;
    logic [CNT_W_L-1:0] r_cnt;
    logic [N-1:0]       r_quot;
    logic [N-1:0]       r_rem;
    logic               r_rdy;
    logic               r_dbz;

    logic               w_accept;
    logic               w_last;
    logic [N-1:0]       w_a_mag;
    logic [N-1:0]       w_b_mag;
    logic [N:0]         w_r_next;
    logic [N-1:0]       w_d_next;
    logic               w_qbit;
    logic [N-1:0]       w_quot_fix;
    logic [N-1:0]       w_rem_fix;
    logic [N-1:0]       w_zero_rem;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == CNT_W_L'(N - 1));

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;

    // Divide magnitudes; signs are restored in DONE so latency matches unsigned.
    assign w_a_mag    = a[N-1] ? -a : a;
    assign w_b_mag    = b[N-1] ? -b : b;
    assign w_quot_fix = r_neg_q ? -r_d : r_d;
    assign w_rem_fix  = r_neg_r ? -r_r[N-1:0] : r_r[N-1:0];
    assign w_zero_rem = r_neg_r ? -r_d : r_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= a[N-1] ^ b[N-1];
            r_neg_r <= a[N-1];
        end
    end
`else
    assign w_a_mag    = a;
    assign w_b_mag    = b;
    assign w_quot_fix = r_d;
    assign w_rem_fix  = r_r[N-1:0];
    assign w_zero_rem = r_d;
`endif

    div_step #(.N(N)) u_step (
        .r      (r_r),
        .d      (r_d),
        .b      (r_b),
        .r_next (w_r_next),
        .d_next (w_d_next),
        .qbit   (w_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = (b == '0) ? DONE : DIV;
            DIV:  if (w_last) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == DIV) || (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d    <= '0;
            r_r    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_rdy  <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_d   <= w_a_mag;
                        r_b   <= w_b_mag;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_rdy <= 1'b0;
                        r_dbz <= 1'b0;
                    end
                end
                DIV: begin
                    r_r   <= w_r_next;
                    r_d   <= w_d_next;
                    r_cnt <= r_cnt + CNT_W_L'(1);
                end
                DONE: begin
                    r_rdy <= 1'b1;
                    if (r_b == '0) begin
                        r_quot <= '1;
                        r_rem  <= w_zero_rem;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quot        = r_quot;
    assign rem         = r_rem;
    assign data_rdy    = r_rdy;
    assign div_by_zero = r_dbz;
    assign state       = r_state;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded directed bench for div_seq: a 256-bit instance plus a small 8-bit one.
module tb_div_seq;

    localparam int unsigned N = 256;
    localparam int unsigned M = 8;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic [31:0]  lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] quot, rem;
    logic         busy, data_rdy, div_by_zero;
    logic [1:0]   state;

    logic         s_start = 1'b0;
    logic [M-1:0] s_a = '0;
    logic [M-1:0] s_b = '0;
    logic [M-1:0] s_quot, s_rem;
    logic         s_busy, s_rdy, s_dbz;
    logic [1:0]   s_state;

    exp_t         sb[$];
    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    int unsigned  cyc = 0;
    int unsigned  t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .quot(quot), .rem(rem), .busy(busy), .data_rdy(data_rdy),
        .div_by_zero(div_by_zero), .state(state)
    );

    div_seq #(.N(M)) dut8 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
        .quot(s_quot), .rem(s_rem), .busy(s_busy), .data_rdy(s_rdy),
        .div_by_zero(s_dbz), .state(s_state)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s got=%h want=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib);
        exp_t e;
        if (ib == '0) begin
            e.q = '1; e.r = ia; e.dbz = 1'b1; e.lat = 2;
        end else begin
            e.q = ia / ib; e.r = ia % ib; e.dbz = 1'b0; e.lat = N + 2;
        end
        return e;
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v = '0;
        for (int unsigned i = 0; i < N / 32; i++) v = {v[N-33:0], 32'($urandom())};
        return v;
    endfunction

    // Accept edge is counted as latency cycle 1.
    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input string tag);
        sb.push_back(model(ia, ib));
        a = ia; b = ib; start = 1'b1;
        tick();
        t_acc = cyc;
        start = 1'b0;
        check({tag, ".busy_acc"}, N'(busy), N'(1));
        check({tag, ".rdy_acc"}, N'(data_rdy), N'(0));
    endtask

    task automatic wait_res(input string tag);
        exp_t        e;
        int unsigned guard = 0;
        while (!data_rdy && guard < 2 * N + 20) begin
            tick();
            guard++;
        end
        check({tag, ".rdy"}, N'(data_rdy), N'(1));
        e = sb.pop_front();
        check({tag, ".lat"}, N'(cyc - t_acc + 1), N'(e.lat));
        check({tag, ".quot"}, quot, e.q);
        check({tag, ".rem"}, rem, e.r);
        check({tag, ".dbz"}, N'(div_by_zero), N'(e.dbz));
        check({tag, ".busy"}, N'(busy), N'(0));
    endtask

    function automatic logic [2*M-1:0] model8(input logic [M-1:0] ia, input logic [M-1:0] ib);
        logic [M-1:0] q, r;
        if (ib == '0) begin
            q = '1; r = ia;
        end else begin
`ifdef SIGNED_DIV_EN
            if (ia == 8'h80 && ib == 8'hFF) begin
                q = 8'h80; r = '0;
            end else begin
                q = M'($signed(ia) / $signed(ib));
                r = M'($signed(ia) % $signed(ib));
            end
`else
            q = ia / ib; r = ia % ib;
`endif
        end
        return {q, r};
    endfunction

    task automatic run8(input logic [M-1:0] ia, input logic [M-1:0] ib, input string tag);
        logic [2*M-1:0] e;
        int unsigned    t0;
        int unsigned    guard = 0;
        e = model8(ia, ib);
        s_a = ia; s_b = ib; s_start = 1'b1;
        tick();
        t0 = cyc;
        s_start = 1'b0;
        while (!s_rdy && guard < 40) begin
            tick();
            guard++;
        end
        check({tag, ".rdy"}, N'(s_rdy), N'(1));
        check({tag, ".lat"}, N'(cyc - t0 + 1), N'((ib == '0) ? 2 : M + 2));
        check({tag, ".quot"}, N'(s_quot), N'(e[2*M-1:M]));
        check({tag, ".rem"}, N'(s_rem), N'(e[M-1:0]));
        check({tag, ".dbz"}, N'(s_dbz), N'(ib == '0));
    endtask

    initial begin
        logic [N-1:0] big;
        #1;
        check("rst.quot", quot, '0);
        check("rst.rem", rem, '0);
        check("rst.flags", N'({busy, data_rdy, div_by_zero}), N'(0));
        check("rst.state", N'(state), N'(0));
        tick();
        rst = 1'b1;
        tick();

        issue(N'(100), N'(7), "t1");
        wait_res("t1");

        issue('1, N'(1), "t2a");
        wait_res("t2a");
        big = '0;
        big[N-1] = 1'b1;
        issue(N'(5), big, "t2b");
        wait_res("t2b");

        issue(N'(16'h1234), '0, "t3");
        wait_res("t3");

        issue(N'(1000), N'(3), "t4");
        repeat (10) tick();
        a = N'(77); b = N'(5); start = 1'b1;
        tick();
        start = 1'b0;
        check("t4.state_div", N'(state), N'(1));
        wait_res("t4");
        issue(N'(9), N'(4), "b2b");
        wait_res("b2b");
        repeat (3) tick();
        check("b2b.idle", N'(busy), N'(0));
        check("b2b.sticky", N'(data_rdy), N'(1));

        issue(rnd(), rnd() >> 100, "t5");
        repeat (100) tick();
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        check("t5.quot", quot, '0);
        check("t5.rem", rem, '0);
        check("t5.flags", N'({busy, data_rdy, div_by_zero}), N'(0));
        check("t5.state", N'(state), N'(0));
        tick();
        rst = 1'b1;
        tick();
        issue(N'(12345), N'(100), "t5b");
        wait_res("t5b");

        for (int unsigned i = 0; i < 2; i++) begin
            big = rnd() >> $urandom_range(0, 200);
            if (big == '0) big = N'(3);
            issue(rnd(), big, "rnd");
            wait_res("rnd");
        end

        run8(8'hF9, 8'h02, "s1");
        run8(8'h07, 8'hFE, "s2");
        run8(8'h80, 8'hFF, "s3");
        run8(8'd200, 8'd7, "s4");
        run8(8'hFB, 8'h00, "s5");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
